dma_burst_engine: RTL
=====================

DMA_BURST_ENGINE -- requirements
Module: dma_burst_engine

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, meaning the maximum words per bus burst (legal 1..256).
REQ-002 SHALL have parameter BUF_AW, default 9, meaning the buffer word-address width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the transfer word-count width.
REQ-004 Ports SHALL be, in this order:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that launches a transfer; ignored unless idle.
dir_read  in  1  1 = bus->buffer, 0 = buffer->bus; sampled at start.
bus_addr  in  32  word-aligned start bus address; sampled at start.
buf_addr  in  BUF_AW  start buffer address; sampled at start.
word_count  in  CNT_W  words to move; sampled at start; 0 = done immediately.
busy / done / error  out  1  active status / one-cycle completion pulse / one-cycle abort pulse.
pushAddress, popAddress  out  BUF_AW  buffer write / read address.
pushData  out  32  buffer write data; push  out  1  write strobe.
popData  in  32  buffer read data, valid one cycle after popAddress.
address_dataIN  in  32; end_transactionIN, data_validIN, busyIN, errorIN  in  1  bus inputs.
address_dataOUT  out  32; byte_enableOUT  out  4; burst_sizeOUT  out  8; read_n_writeOUT, begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT  out  1  bus outputs.
request  out  1; granted  in  1  arbiter handshake.

Function
REQ-005 States SHALL be IDLE, REQUEST, HANDSHAKE, WR_FETCH, WR_DATA, RD_DATA, END.
REQ-006 IDLE->REQUEST on start with word_count>0; start with word_count=0 SHALL pulse done the next cycle and stay IDLE.
REQ-007 Each burst length SHALL be min(remaining, MAX_BURST); burst_sizeOUT = length-1, driven only in HANDSHAKE, else 0.
REQ-008 request SHALL be high only in REQUEST; REQUEST->HANDSHAKE when granted=1.
REQ-009 HANDSHAKE (one cycle): begin_transactionOUT=1, address_dataOUT=current bus address, byte_enableOUT=4'hF, read_n_writeOUT=dir_read; next WR_FETCH (write) or RD_DATA (read).
REQ-010 WR_FETCH (one cycle) SHALL present popAddress for the first word; WR_DATA SHALL drive data_validOUT=1 with address_dataOUT=popped word, holding word and popAddress while busyIN=1, advancing one word per cycle with busyIN=0, with the next popAddress issued in the same cycle as acceptance so no bubble occurs.
REQ-011 end_transactionOUT SHALL pulse one cycle in END after the last burst word is accepted (or on errorIN).
REQ-012 RD_DATA SHALL push address_dataIN to pushAddress on every data_validIN=1 cycle (push=1, pushData=address_dataIN), incrementing the buffer address; RD_DATA->END on end_transactionIN=1, data on that cycle still captured.
REQ-013 After each burst: bus address += 4*length (32-bit wrap), buffer address += length (BUF_AW wrap), remaining -= length; END->REQUEST if remaining>0, else IDLE with done pulse.
REQ-014 errorIN=1 in any non-IDLE state SHALL force IDLE next cycle, drop request, pulse error, and not pulse done.
REQ-015 busyOUT SHALL be 0 at all times; busy SHALL be 1 in every non-IDLE state.
REQ-016 start while busy SHALL be ignored without altering the transfer.

Reset
REQ-017 reset_n=0 SHALL asynchronously force IDLE, clear all counters/addresses, and drive every output to 0, including mid-burst.
REQ-018 After reset release the block SHALL accept start on the first clock edge.

Structure
REQ-019 State encoding and bus byte_enable/burst constants SHALL live in shared package dma_pkg.
REQ-020 Burst length/address-advance arithmetic SHALL be one sub-module, dma_burst_calc; the FSM and datapath stay in dma_burst_engine.

Verification
REQ-021 Write, word_count=40, MAX_BURST=16, bus_addr=0x4000_0000 -> three bursts, burst_sizeOUT 15,15,7, handshake addresses 0x4000_0000, 0x4000_0040, 0x4000_0080, one done pulse.
REQ-022 Read, word_count=5, slave data 0xA0..0xA4 with a data_validIN gap -> buffer 0..4 holds 0xA0..0xA4, five push pulses.
REQ-023 Write burst with busyIN high for 3 cycles mid-burst -> address_dataOUT and popAddress held steady, no word lost or duplicated.
REQ-024 errorIN on third data word of a 16-word write -> IDLE next cycle, error pulse, no done, request low.
REQ-025 reset_n low mid-read burst -> all outputs 0 immediately; new start after release completes normally.
REQ-026 granted withheld 10 cycles, plus start pulsed while busy -> request held high, no handshake until grant, second start ignored.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding and bus constants for the DMA burst engine
package dma_pkg;
    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        HANDSHAKE,
        WR_FETCH,
        WR_DATA,
        RD_DATA,
        END
    } state_t;
    localparam int BURST_LEN_W  = 9;
    localparam int BURST_SIZE_W = 8;
    localparam logic [3:0] BE_ALL  = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;
    localparam logic [BURST_SIZE_W-1:0] BURST_NONE = '0;
endpackage

// File: rtl/dma_burst_calc.sv
// dma_burst_calc: burst length and post-burst address/count advance
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int BUF_AW    = 9,
    parameter int CNT_W     = 16
) (
    input  logic [CNT_W-1:0]        remaining,
    input  logic [31:0]             bus_addr,
    input  logic [BUF_AW-1:0]       buf_addr,
    output logic [BURST_LEN_W-1:0]  len,
    output logic [BURST_SIZE_W-1:0] burst_size,
    output logic [31:0]             next_bus_addr,
    output logic [BUF_AW-1:0]       next_buf_addr,
    output logic [CNT_W-1:0]        next_remaining
);
    always_comb begin
        len            = (32'(remaining) < MAX_BURST) ? BURST_LEN_W'(remaining) : BURST_LEN_W'(MAX_BURST);
        burst_size     = BURST_SIZE_W'(len - BURST_LEN_W'(1));
        next_bus_addr  = bus_addr + (32'(len) << 2);
        next_buf_addr  = buf_addr + BUF_AW'(len);
        next_remaining = remaining - CNT_W'(len);
    end
endmodule

// File: rtl/dma_burst_engine.sv
// dma_burst_engine: bus-master DMA moving word bursts between a local buffer and the bus
module dma_burst_engine
    import dma_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int BUF_AW    = 9,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              dir_read,
    input  logic [31:0]       bus_addr,
    input  logic [BUF_AW-1:0] buf_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [BUF_AW-1:0] pushAddress,
    output logic [BUF_AW-1:0] popAddress,
    output logic [31:0]       pushData,
    output logic              push,
    input  logic [31:0]       popData,
    input  logic [31:0]       address_dataIN,
    input  logic              end_transactionIN,
    input  logic              data_validIN,
    input  logic              busyIN,
    input  logic              errorIN,
    output logic [31:0]       address_dataOUT,
    output logic [3:0]        byte_enableOUT,
    output logic [7:0]        burst_sizeOUT,
    output logic              read_n_writeOUT,
    output logic              begin_transactionOUT,
    output logic              end_transactionOUT,
    output logic              data_validOUT,
    output logic              busyOUT,
    output logic              request,
    input  logic              granted
);
    localparam logic [BUF_AW-1:0]      BUF_STEP = BUF_AW'(1);
    localparam logic [BURST_LEN_W-1:0] LEN_STEP = BURST_LEN_W'(1);

    state_t                   state_q, state_d;
    logic                     dir_q, dir_d;
    logic [31:0]              bus_q, bus_d;
    logic [BUF_AW-1:0]        buf_q, buf_d;
    logic [CNT_W-1:0]         rem_q, rem_d;
    logic [BUF_AW-1:0]        ptr_q, ptr_d;
    logic [BURST_LEN_W-1:0]   beat_q, beat_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic [BURST_LEN_W-1:0]   len;
    logic [BURST_SIZE_W-1:0]  burst_size;
    logic [31:0]              next_bus;
    logic [BUF_AW-1:0]        next_buf;
    logic [CNT_W-1:0]         next_rem;
    logic                     hs;

    dma_burst_calc #(
        .MAX_BURST(MAX_BURST),
        .BUF_AW   (BUF_AW),
        .CNT_W    (CNT_W)
    ) u_calc (
        .remaining     (rem_q),
        .bus_addr      (bus_q),
        .buf_addr      (buf_q),
        .len           (len),
        .burst_size    (burst_size),
        .next_bus_addr (next_bus),
        .next_buf_addr (next_buf),
        .next_remaining(next_rem)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            bus_q   <= '0;
            buf_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            bus_q   <= bus_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        bus_d   = bus_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                dir_d   = dir_read;
                bus_d   = bus_addr;
                buf_d   = buf_addr;
                rem_d   = word_count;
                done_d  = (word_count == '0);
                state_d = (word_count == '0) ? IDLE : REQUEST;
            end
            REQUEST: state_d = granted ? HANDSHAKE : REQUEST;
            HANDSHAKE: begin
                ptr_d   = buf_q;
                beat_d  = '0;
                state_d = dir_q ? RD_DATA : WR_FETCH;
            end
            WR_FETCH: state_d = WR_DATA;
            // a word is consumed only on a cycle the slave is not busy
            WR_DATA: if (!busyIN) begin
                ptr_d   = ptr_q + BUF_STEP;
                beat_d  = beat_q + LEN_STEP;
                state_d = (beat_q == len - LEN_STEP) ? END : WR_DATA;
            end
            RD_DATA: begin
                ptr_d   = data_validIN ? ptr_q + BUF_STEP : ptr_q;
                state_d = end_transactionIN ? END : RD_DATA;
            end
            END: begin
                bus_d   = next_bus;
                buf_d   = next_buf;
                rem_d   = next_rem;
                done_d  = (next_rem == '0);
                state_d = (next_rem == '0) ? IDLE : REQUEST;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && errorIN) begin
            state_d = IDLE;
            done_d  = 1'b0;
            error_d = 1'b1;
        end
    end

    // the next pop address goes out in the accepting cycle so the word is ready without a bubble
    always_comb begin
        hs                   = (state_q == HANDSHAKE);
        busy                 = (state_q != IDLE);
        done                 = done_q;
        error                = error_q;
        request              = (state_q == REQUEST);
        begin_transactionOUT = hs;
        burst_sizeOUT        = hs ? burst_size : BURST_NONE;
        byte_enableOUT       = hs ? BE_ALL : BE_NONE;
        read_n_writeOUT      = hs & dir_q;
        data_validOUT        = (state_q == WR_DATA);
        address_dataOUT      = hs ? bus_q : (data_validOUT ? popData : 32'h0);
        popAddress           = (state_q == WR_FETCH) ? ptr_q :
                               (state_q == WR_DATA) ? (busyIN ? ptr_q : ptr_q + BUF_STEP) : '0;
        push                 = (state_q == RD_DATA) & data_validIN;
        pushAddress          = (state_q == RD_DATA) ? ptr_q : '0;
        pushData             = push ? address_dataIN : 32'h0;
        end_transactionOUT   = (state_q == END) |
                               (errorIN & (state_q inside {HANDSHAKE, WR_FETCH, WR_DATA, RD_DATA}));
        busyOUT              = 1'b0;
    end
endmodule
